// File: rtl/data_mem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter: FSM state encoding,
// master index constants and default burst limit.
package arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } arb_state_e;

  localparam logic M_CPU    = 1'b0;
  localparam logic M_LOADER = 1'b1;

  localparam int DEFAULT_MAX_BURST = 4;
  localparam int BURST_CNT_W       = 4;

  // Saturating 8-bit increment used by the wait-length statistic.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/data_mem_arbiter_if.sv
// Bus bundle between the two masters, the arbiter and the data memory.
// The arbiter uses the slave modport (it serves the masters and drives the
// memory); the surrounding system uses the master modport.
interface data_mem_arbiter_if #(
  parameter int ADDR_WIDTH = 30,
  parameter int DATA_WIDTH = 32,
  parameter int NB_COL     = 4
) ();

  logic                  m0_req;
  logic [ADDR_WIDTH-1:0] m0_addr;
  logic [NB_COL-1:0]     m0_wbe;
  logic [DATA_WIDTH-1:0] m0_wdata;
  logic                  m0_ack;
  logic [DATA_WIDTH-1:0] m0_rdata;

  logic                  m1_req;
  logic [ADDR_WIDTH-1:0] m1_addr;
  logic [NB_COL-1:0]     m1_wbe;
  logic [DATA_WIDTH-1:0] m1_wdata;
  logic                  m1_ack;
  logic [DATA_WIDTH-1:0] m1_rdata;

  logic                  mem_ce;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [NB_COL-1:0]     mem_wbe;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] mem_rdata;

  modport slave (
    input  m0_req, m0_addr, m0_wbe, m0_wdata,
    output m0_ack, m0_rdata,
    input  m1_req, m1_addr, m1_wbe, m1_wdata,
    output m1_ack, m1_rdata,
    output mem_ce, mem_addr, mem_wbe, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output m0_req, m0_addr, m0_wbe, m0_wdata,
    input  m0_ack, m0_rdata,
    output m1_req, m1_addr, m1_wbe, m1_wdata,
    input  m1_ack, m1_rdata,
    input  mem_ce, mem_addr, mem_wbe, mem_wdata,
    output mem_rdata
  );

endinterface

// File: rtl/data_mem_arbiter_priority_sel.sv
// Combinational grant decision: master 0 has fixed priority unless it has
// already used up MAX_BURST consecutive grants while master 1 was waiting.
module arb_priority_sel
  import arb_pkg::*;
#(
  parameter int MAX_BURST = DEFAULT_MAX_BURST
) (
  input  logic                   m0_req,
  input  logic                   m1_req,
  input  logic [BURST_CNT_W-1:0] burst_cnt,
  output logic                   grant_valid,
  output logic                   grant_sel
);

  localparam logic [BURST_CNT_W-1:0] MAX_BURST_C = BURST_CNT_W'(MAX_BURST);

  // Pick the winner among the (already qualified) requests.
  always_comb begin
    grant_valid = m0_req | m1_req;
    grant_sel   = M_CPU;
    if (m0_req && m1_req) begin
      grant_sel = (burst_cnt < MAX_BURST_C) ? M_CPU : M_LOADER;
    end else if (m1_req) begin
      grant_sel = M_LOADER;
    end
  end

endmodule

// File: rtl/data_mem_arbiter.sv
// Two-master arbiter for the single data-memory port (master 0 = CPU data
// port, master 1 = loader/DMA). Each access takes an ACCESS cycle (memory
// enabled) followed by a RESP cycle (ack pulse, registered read data).
// Optional statistics outputs are enabled by defining ARB_STATS_EN.
module data_mem_arbiter
  import arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 30,
  parameter int DATA_WIDTH = 32,
  parameter int NB_COL     = 4,
  parameter int MAX_BURST  = DEFAULT_MAX_BURST
) (
  input  logic                clk,
  input  logic                rst_n,
  data_mem_arbiter_if.slave   bus
`ifdef ARB_STATS_EN
  ,
  output logic [15:0]         m0_grant_cnt,
  output logic [15:0]         m1_grant_cnt,
  output logic [7:0]          wait_max
`endif
);

  localparam logic [BURST_CNT_W-1:0] MAX_BURST_C = BURST_CNT_W'(MAX_BURST);

  arb_state_e              state_q, state_d;
  logic                    sel_q;
  logic                    rd_q;
  logic [BURST_CNT_W-1:0]  burst_cnt_q;

  logic                    eval_pt;
  logic                    req0_eff, req1_eff;
  logic                    grant, grant_sel;
  logic [NB_COL-1:0]       gnt_wbe;

  logic                    m0_ack_q, m1_ack_q;
  logic [DATA_WIDTH-1:0]   m0_rdata_q, m1_rdata_q;

  logic                    mem_ce_c;
  logic [ADDR_WIDTH-1:0]   mem_addr_c;
  logic [NB_COL-1:0]       mem_wbe_c;
  logic [DATA_WIDTH-1:0]   mem_wdata_c;

  // Arbitration happens in IDLE and RESP; the master being acked in RESP
  // still shows its old req, so it is masked out to avoid a double grant.
  assign eval_pt  = (state_q != ACCESS);
  assign req0_eff = eval_pt && bus.m0_req && !(state_q == RESP && sel_q == M_CPU);
  assign req1_eff = eval_pt && bus.m1_req && !(state_q == RESP && sel_q == M_LOADER);
  assign gnt_wbe  = (grant_sel == M_LOADER) ? bus.m1_wbe : bus.m0_wbe;

  arb_priority_sel #(
    .MAX_BURST (MAX_BURST)
  ) u_priority_sel (
    .m0_req      (req0_eff),
    .m1_req      (req1_eff),
    .burst_cnt   (burst_cnt_q),
    .grant_valid (grant),
    .grant_sel   (grant_sel)
  );

  // Next-state logic: every grant opens an ACCESS, every ACCESS is answered.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = grant ? ACCESS : IDLE;
      ACCESS:  state_d = RESP;
      RESP:    state_d = grant ? ACCESS : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register; async reset also aborts an access in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Latch the winner and whether its access is a read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_q <= M_CPU;
      rd_q  <= 1'b0;
    end else if (grant) begin
      sel_q <= grant_sel;
      rd_q  <= (gnt_wbe == '0);
    end
  end

  // Count master-0 grants taken while master 1 waits; any loader grant or an
  // evaluation without a loader request restarts the count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      burst_cnt_q <= '0;
    end else if (eval_pt) begin
      if (!req1_eff || (grant && grant_sel == M_LOADER)) begin
        burst_cnt_q <= '0;
      end else if (grant && burst_cnt_q < MAX_BURST_C) begin
        burst_cnt_q <= burst_cnt_q + 1'b1;
      end
    end
  end

  // Response stage: one-cycle ack and read-data capture at the end of ACCESS.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m0_ack_q   <= 1'b0;
      m1_ack_q   <= 1'b0;
      m0_rdata_q <= '0;
      m1_rdata_q <= '0;
    end else begin
      m0_ack_q <= (state_q == ACCESS) && (sel_q == M_CPU);
      m1_ack_q <= (state_q == ACCESS) && (sel_q == M_LOADER);
      if (state_q == ACCESS && rd_q) begin
        if (sel_q == M_LOADER) begin
          m1_rdata_q <= bus.mem_rdata;
        end else begin
          m0_rdata_q <= bus.mem_rdata;
        end
      end
    end
  end

  // Memory port mux: only the selected master is visible, and only in ACCESS.
  always_comb begin
    mem_ce_c    = 1'b0;
    mem_addr_c  = '0;
    mem_wbe_c   = '0;
    mem_wdata_c = '0;
    if (state_q == ACCESS) begin
      mem_ce_c = 1'b1;
      if (sel_q == M_LOADER) begin
        mem_addr_c  = bus.m1_addr;
        mem_wbe_c   = bus.m1_wbe;
        mem_wdata_c = bus.m1_wdata;
      end else begin
        mem_addr_c  = bus.m0_addr;
        mem_wbe_c   = bus.m0_wbe;
        mem_wdata_c = bus.m0_wdata;
      end
    end
  end

  assign bus.mem_ce    = mem_ce_c;
  assign bus.mem_addr  = mem_addr_c;
  assign bus.mem_wbe   = mem_wbe_c;
  assign bus.mem_wdata = mem_wdata_c;
  assign bus.m0_ack    = m0_ack_q;
  assign bus.m1_ack    = m1_ack_q;
  assign bus.m0_rdata  = m0_rdata_q;
  assign bus.m1_rdata  = m1_rdata_q;

`ifdef ARB_STATS_EN
  logic [7:0] wait_cnt_q;
  logic       m1_pending;

  // Loader is waiting when it requests but is not already being served.
  assign m1_pending = bus.m1_req && !(state_q != IDLE && sel_q == M_LOADER);

  // Grant counters (wrapping) and longest loader wait (saturating).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m0_grant_cnt <= '0;
      m1_grant_cnt <= '0;
      wait_max     <= '0;
      wait_cnt_q   <= '0;
    end else begin
      if (grant && grant_sel == M_CPU) begin
        m0_grant_cnt <= m0_grant_cnt + 16'd1;
      end
      if (grant && grant_sel == M_LOADER) begin
        m1_grant_cnt <= m1_grant_cnt + 16'd1;
        if (wait_cnt_q > wait_max) begin
          wait_max <= wait_cnt_q;
        end
        wait_cnt_q <= '0;
      end else if (m1_pending) begin
        wait_cnt_q <= sat_inc8(wait_cnt_q);
      end else begin
        wait_cnt_q <= '0;
      end
    end
  end
`endif

endmodule
